maze_solver_param: RTL and testbench
====================================

MAZE_SOLVER_PARAM -- requirements
Module: maze_solver_param

Interface
REQ-001 Parameter ROW_BITS, default 4, row-index width; grid has 2^ROW_BITS rows.
REQ-002 Parameter COL_BITS, default 4, column-index width; grid has 2^COL_BITS columns.
REQ-003 Parameter MAX_STEPS, default 4096, scan-cycle budget per search; 0 disables the timeout.
REQ-004 Derived: AW = ROW_BITS+COL_BITS; N = 2^AW cells; cell address = {row,col}.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 Start  in  1  begin a search, sampled in IDLE/DONE/FAIL/END only.
REQ-008 Run  in  1  begin path playback, sampled in DONE only.
REQ-009 src_addr  in  AW  start cell, captured on accepted Start.
REQ-010 dst_addr  in  AW  goal cell, captured on accepted Start.
REQ-011 mem_addr  out  AW  maze memory address; mem_rdata is valid in the same cycle.
REQ-012 mem_rdata  in  1  1 = wall, 0 = open.
REQ-013 Busy  out  1  high in INIT, SCAN, BACK, PLAY.
REQ-014 Done  out  1  path found; high in DONE.
REQ-015 Fail  out  1  no path or timeout; high in FAIL.
REQ-016 Timeout  out  1  high in FAIL when the cause was the MAX_STEPS budget.
REQ-017 Move  out  AW  playback cell address; valid only when Move_valid=1, else 0.
REQ-018 Move_valid  out  1  one-cycle qualifier per playback cell.
REQ-019 The_End  out  1  playback complete; high in END.

Function
REQ-020 States: IDLE, INIT, SCAN, BACK, DONE, FAIL, PLAY, END.
REQ-021 Storage: N-bit visited bitmap; N-entry path stack of AW-bit addresses; stack pointer sp (0..N); direction counter d (2 bits); scan counter sized for MAX_STEPS.
REQ-022 IDLE/DONE/FAIL/END + Start=1 -> INIT: capture src/dst, clear visited, sp=0, scan counter=0, Timeout=0.
REQ-023 INIT (1 cycle): mem_addr=src; if mem_rdata=1 -> FAIL; else push src, mark src visited, cur=src, d=0; if src==dst -> DONE, else -> SCAN.
REQ-024 SCAN, one direction per cycle, order d=0 up (row-1), 1 right (col+1), 2 down (row+1), 3 left (col-1).
REQ-025 Neighbour is accepted iff in-grid (no wrap at edges), not visited, and mem_rdata=0 with mem_addr=neighbour.
REQ-026 When the neighbour is out of grid, mem_addr holds cur and mem_rdata is ignored.
REQ-027 On accept: push neighbour, mark visited, cur=neighbour, d=0; if neighbour==dst -> DONE.
REQ-028 On reject: d<3 -> d+1; d=3 -> BACK.
REQ-029 BACK (1 cycle): if sp==1 -> FAIL; else sp-1, cur = new top of stack, d=0 -> SCAN.
REQ-030 Each SCAN cycle increments the scan counter; when it reaches MAX_STEPS (MAX_STEPS!=0) -> FAIL with Timeout=1, taking priority over accept/reject in that cycle.
REQ-031 DONE: hold the stack; Run=1 -> PLAY with idx=0; Start has priority over Run when both are high.
REQ-032 PLAY: each cycle Move=stack[idx], Move_valid=1, idx+1; after idx=sp-1 -> END. Path length = sp cells, src first, dst last.
REQ-033 END: The_End=1 until Start or rst; Start restarts via INIT.
REQ-034 Start and Run are ignored in INIT, SCAN, BACK, PLAY; Run is ignored outside DONE.
REQ-035 Stack overflow cannot occur: the visited bitmap bounds pushes to N.
REQ-036 Done, Fail, Timeout, The_End are Moore outputs decoded from registered state.

Reset
REQ-037 rst=1 at a clock edge forces IDLE, sp=0, d=0, idx=0, scan counter=0, visited cleared, with priority over all inputs.
REQ-038 While in reset and after it: Busy=Done=Fail=Timeout=The_End=Move_valid=0, Move=0, mem_addr=0.
REQ-039 rst asserted mid-SCAN or mid-PLAY aborts the operation; nothing is emitted afterwards until a new Start.

Verification
REQ-040 Open 4x4 grid (ROW_BITS=COL_BITS=2), src=0, dst=15 -> Done; Run then gives Move 0,1,2,3,7,11,15 on consecutive cycles, then The_End=1.
REQ-041 Walls isolate dst (cells 11 and 14 walled), src=0, dst=15 -> Fail=1, Timeout=0 after every reachable cell is exhausted.
REQ-042 src cell is a wall -> Fail=1 two cycles after Start.
REQ-043 src==dst=5 -> Done after INIT; playback gives a single Move=5, then The_End.
REQ-044 Open 16x16 grid, MAX_STEPS=10, src=0, dst=255 -> Fail=1, Timeout=1.
REQ-045 rst pulsed mid-PLAY -> all outputs 0 the next cycle, state IDLE; Start pulsed mid-SCAN -> ignored, and the search result is unchanged.

Source files
------------

// File: rtl/maze_solver_param.sv
// Depth-first maze search over a 2^ROW_BITS x 2^COL_BITS grid with a path stack,
// followed by optional playback of the found path one cell per cycle.
module maze_solver_param #(
    parameter int ROW_BITS  = 4,
    parameter int COL_BITS  = 4,
    parameter int MAX_STEPS = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         Start,
    input  logic                         Run,
    input  logic [ROW_BITS+COL_BITS-1:0] src_addr,
    input  logic [ROW_BITS+COL_BITS-1:0] dst_addr,
    output logic [ROW_BITS+COL_BITS-1:0] mem_addr,
    input  logic                         mem_rdata,
    output logic                         Busy,
    output logic                         Done,
    output logic                         Fail,
    output logic                         Timeout,
    output logic [ROW_BITS+COL_BITS-1:0] Move,
    output logic                         Move_valid,
    output logic                         The_End,
    output logic [2:0]                   dbg_state
);

    localparam int AW = ROW_BITS + COL_BITS;
    localparam int N  = 1 << AW;
    localparam int SW = (MAX_STEPS > 0) ? $clog2(MAX_STEPS + 1) : 1;
    localparam logic [SW-1:0] STEP_LIMIT = SW'(MAX_STEPS);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_SCAN = 3'd2;
    localparam logic [2:0] S_BACK = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_FAIL = 3'd5;
    localparam logic [2:0] S_PLAY = 3'd6;
    localparam logic [2:0] S_END  = 3'd7;

    logic [2:0]          state;
    logic [AW-1:0]       src_q;
    logic [AW-1:0]       dst_q;
    logic [AW-1:0]       cur;
    logic [N-1:0]        visited;
    logic [AW-1:0]       stack [N];
    logic [AW:0]         sp;
    logic [1:0]          d;
    logic [AW-1:0]       idx;
    logic [SW-1:0]       scan_cnt;
    logic                timeout_q;

    logic [ROW_BITS-1:0] row;
    logic [ROW_BITS-1:0] nrow;
    logic [COL_BITS-1:0] col;
    logic [COL_BITS-1:0] ncol;
    logic                in_grid;
    logic [AW-1:0]       nbr;
    logic [SW-1:0]       scan_nxt;
    logic                step_out;
    logic                accept;
    logic                start_ok;
    logic                push_en;
    logic [AW-1:0]       push_data;
    logic [AW:0]         sp_back;
    logic [AW:0]         sp_last;

    // Neighbour of the current cell in direction d; edges do not wrap.
    always_comb begin
        row     = cur[AW-1:COL_BITS];
        col     = cur[COL_BITS-1:0];
        nrow    = row;
        ncol    = col;
        in_grid = 1'b0;
        case (d)
            2'd0: begin
                in_grid = (row != '0);
                nrow    = row - ROW_BITS'(1);
            end
            2'd1: begin
                in_grid = (col != {COL_BITS{1'b1}});
                ncol    = col + COL_BITS'(1);
            end
            2'd2: begin
                in_grid = (row != {ROW_BITS{1'b1}});
                nrow    = row + ROW_BITS'(1);
            end
            default: begin
                in_grid = (col != '0);
                ncol    = col - COL_BITS'(1);
            end
        endcase
        nbr = {nrow, ncol};
    end

    always_comb begin
        scan_nxt  = scan_cnt + SW'(1);
        step_out  = (MAX_STEPS != 0) && (scan_nxt == STEP_LIMIT);
        accept    = (state == S_SCAN) && in_grid && !visited[nbr] && !mem_rdata;
        start_ok  = Start && ((state == S_IDLE) || (state == S_DONE) ||
                              (state == S_FAIL) || (state == S_END));
        push_en   = !rst && (((state == S_INIT) && !mem_rdata) || (accept && !step_out));
        push_data = (state == S_INIT) ? src_q : nbr;
        sp_back   = sp - (AW+1)'(2);
        sp_last   = sp - (AW+1)'(1);
    end

    always_comb begin
        mem_addr = '0;
        case (state)
            S_INIT:  mem_addr = src_q;
            S_SCAN:  mem_addr = in_grid ? nbr : cur;
            default: mem_addr = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            cur       <= '0;
            visited   <= '0;
            sp        <= '0;
            d         <= '0;
            idx       <= '0;
            scan_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (start_ok) begin
            // Start wins over Run in DONE and restarts from every resting state.
            state     <= S_INIT;
            src_q     <= src_addr;
            dst_q     <= dst_addr;
            visited   <= '0;
            sp        <= '0;
            d         <= '0;
            scan_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (mem_rdata) begin
                        state <= S_FAIL;
                    end else begin
                        visited[src_q] <= 1'b1;
                        sp             <= (AW+1)'(1);
                        cur            <= src_q;
                        d              <= '0;
                        state          <= (src_q == dst_q) ? S_DONE : S_SCAN;
                    end
                end
                S_SCAN: begin
                    scan_cnt <= scan_nxt;
                    if (step_out) begin
                        state     <= S_FAIL;
                        timeout_q <= 1'b1;
                    end else if (accept) begin
                        visited[nbr] <= 1'b1;
                        sp           <= sp + (AW+1)'(1);
                        cur          <= nbr;
                        d            <= '0;
                        if (nbr == dst_q) state <= S_DONE;
                    end else if (d == 2'd3) begin
                        state <= S_BACK;
                    end else begin
                        d <= d + 2'd1;
                    end
                end
                S_BACK: begin
                    if (sp == (AW+1)'(1)) begin
                        state <= S_FAIL;
                    end else begin
                        sp    <= sp_last;
                        cur   <= stack[sp_back[AW-1:0]];
                        d     <= '0;
                        state <= S_SCAN;
                    end
                end
                S_DONE: begin
                    if (Run) begin
                        idx   <= '0;
                        state <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    idx <= idx + AW'(1);
                    if ({1'b0, idx} == sp_last) state <= S_END;
                end
                S_IDLE, S_FAIL, S_END: state <= state;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Path stack is plain storage; sp alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) stack[sp[AW-1:0]] <= push_data;
    end

    // Move/Move_valid is a valid-only stream: no ready exists, so the consumer
    // must take one cell on every cycle Move_valid is high; Move is 0 otherwise.
    always_comb begin
        Busy       = (state == S_INIT) || (state == S_SCAN) ||
                     (state == S_BACK) || (state == S_PLAY);
        Done       = (state == S_DONE);
        Fail       = (state == S_FAIL);
        Timeout    = (state == S_FAIL) && timeout_q;
        The_End    = (state == S_END);
        Move_valid = (state == S_PLAY);
        Move       = (state == S_PLAY) ? stack[idx] : '0;
        dbg_state  = state;
    end

endmodule

// File: tb/tb_maze_solver_param.sv
// Self-checking bench: a 4x4 instance and a 16x16 instance with a 10-cycle budget,
// compared against an algorithmic depth-first search model.
module tb_maze_solver_param;

    localparam int LAT_LIMIT = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic       maze [256];

    logic       start_a, run_a, mem_rdata_a;
    logic [3:0] src_a, dst_a, mem_addr_a, move_a;
    logic       busy_a, done_a, fail_a, to_a, mv_a, end_a;
    logic [2:0] st_a;

    logic       start_b, run_b, mem_rdata_b;
    logic [7:0] src_b, dst_b, mem_addr_b, move_b;
    logic       busy_b, done_b, fail_b, to_b, mv_b, end_b;
    logic [2:0] st_b;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    int         m_res;
    int         m_lat;
    int         m_path[$];

    logic       rst_prev;

    always #5 clk = ~clk;

    assign mem_rdata_a = maze[{4'b0, mem_addr_a}];
    assign mem_rdata_b = maze[mem_addr_b];

    maze_solver_param #(.ROW_BITS(2), .COL_BITS(2)) dut_a (
        .clk(clk), .rst(rst), .Start(start_a), .Run(run_a),
        .src_addr(src_a), .dst_addr(dst_a), .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a),
        .Busy(busy_a), .Done(done_a), .Fail(fail_a), .Timeout(to_a),
        .Move(move_a), .Move_valid(mv_a), .The_End(end_a), .dbg_state(st_a)
    );

    maze_solver_param #(.ROW_BITS(4), .COL_BITS(4), .MAX_STEPS(10)) dut_b (
        .clk(clk), .rst(rst), .Start(start_b), .Run(run_b),
        .src_addr(src_b), .dst_addr(dst_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
        .Busy(busy_b), .Done(done_b), .Fail(fail_b), .Timeout(to_b),
        .Move(move_b), .Move_valid(mv_b), .The_End(end_b), .dbg_state(st_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference search: directions tried up, right, down, left; one cycle per
    // direction tried, one per backtrack, one for the initial source read.
    task automatic model_search(input int rb, input int cb, input int src, input int dst,
                                input int max_steps);
        int rows, cols, steps, cur, r, c, nr, nc, n;
        bit vis [256];
        bit acc;
        rows = 1 << rb;
        cols = 1 << cb;
        m_path.delete();
        m_lat = 1;
        for (int i = 0; i < 256; i++) vis[i] = 1'b0;
        if (maze[src]) begin
            m_res = 1;
            return;
        end
        m_path.push_back(src);
        vis[src] = 1'b1;
        cur = src;
        if (src == dst) begin
            m_res = 0;
            return;
        end
        steps = 0;
        forever begin
            acc = 1'b0;
            for (int dir = 0; dir < 4 && !acc; dir++) begin
                m_lat++;
                steps++;
                if (max_steps != 0 && steps == max_steps) begin
                    m_res = 2;
                    return;
                end
                r = cur / cols;
                c = cur % cols;
                nr = r;
                nc = c;
                case (dir)
                    0: nr = r - 1;
                    1: nc = c + 1;
                    2: nr = r + 1;
                    default: nc = c - 1;
                endcase
                if (nr >= 0 && nr < rows && nc >= 0 && nc < cols) begin
                    n = nr * cols + nc;
                    if (!vis[n] && !maze[n]) begin
                        acc = 1'b1;
                        vis[n] = 1'b1;
                        m_path.push_back(n);
                        cur = n;
                        if (n == dst) begin
                            m_res = 0;
                            return;
                        end
                    end
                end
            end
            if (!acc) begin
                m_lat++;
                if (m_path.size() == 1) begin
                    m_res = 1;
                    return;
                end
                void'(m_path.pop_back());
                cur = m_path[$];
            end
        end
    endtask

    task automatic start_search(input int sel, input int src, input int dst, input bit with_run);
        @(negedge clk);
        if (sel == 0) begin
            src_a = 4'(src); dst_a = 4'(dst); start_a = 1'b1; run_a = with_run;
        end else begin
            src_b = 8'(src); dst_b = 8'(dst); start_b = 1'b1; run_b = with_run;
        end
        @(negedge clk);
        start_a = 1'b0; run_a = 1'b0; start_b = 1'b0; run_b = 1'b0;
        src_a = 4'($urandom); dst_a = 4'($urandom);
        src_b = 8'($urandom); dst_b = 8'($urandom);
    endtask

    // res: 0 done, 1 fail, 2 fail by timeout, -1 nothing within the budget.
    task automatic wait_result(input int sel, input int pulse_at, output int lat, output int res);
        lat = 0;
        res = -1;
        while (res < 0 && lat < LAT_LIMIT) begin
            if (sel == 0) start_a = (lat == pulse_at);
            else          start_b = (lat == pulse_at);
            @(negedge clk);
            lat++;
            if (sel == 0) begin
                if (done_a)      res = 0;
                else if (fail_a) res = to_a ? 2 : 1;
            end else begin
                if (done_b)      res = 0;
                else if (fail_b) res = to_b ? 2 : 1;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic search_and_check(input int sel, input string tag, input int src,
                                    input int dst, input int pulse_at, output int res);
        int lat;
        if (sel == 0) model_search(2, 2, src, dst, 4096);
        else          model_search(4, 4, src, dst, 10);
        start_search(sel, src, dst, 1'b0);
        wait_result(sel, pulse_at, lat, res);
        check({tag, "_result"}, res, m_res);
        check({tag, "_latency"}, lat, m_lat);
    endtask

    task automatic play_a(input string tag);
        logic [7:0] e;
        @(negedge clk);
        run_a = 1'b1;
        @(negedge clk);
        run_a = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_move_valid"}, mv_a, 1);
            check({tag, "_move"}, {4'b0, move_a}, e);
            @(negedge clk);
        end
        check({tag, "_the_end"}, end_a, 1);
        check({tag, "_end_quiet"}, {mv_a, busy_a}, 0);
    endtask

    function automatic bit inv_ok(input logic busy, input logic done, input logic fail,
                                  input logic to, input logic mv, input logic fin,
                                  input logic [7:0] move, input logic [7:0] maddr,
                                  input logic [2:0] st, input logic in_rst);
        bit ok;
        ok = 1'b1;
        if ($countones({busy, done, fail, fin}) > 1) ok = 1'b0;
        if (!mv && move != 8'd0) ok = 1'b0;
        if (to && !fail) ok = 1'b0;
        if (mv && !busy) ok = 1'b0;
        if (in_rst && ({busy, done, fail, to, mv, fin} != 6'd0 || move != 8'd0 ||
                       maddr != 8'd0 || st != 3'd0)) ok = 1'b0;
        return ok;
    endfunction

    always @(posedge clk) rst_prev <= rst;

    always @(negedge clk) begin
        check("invariants_a", inv_ok(busy_a, done_a, fail_a, to_a, mv_a, end_a,
              {4'b0, move_a}, {4'b0, mem_addr_a}, st_a, rst_prev === 1'b1), 1);
        check("invariants_b", inv_ok(busy_b, done_b, fail_b, to_b, mv_b, end_b,
              move_b, mem_addr_b, st_b, rst_prev === 1'b1), 1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int res, lat, src, dst;
        rst = 1'b1;
        start_a = 1'b0; run_a = 1'b0; src_a = '0; dst_a = '0;
        start_b = 1'b0; run_b = 1'b0; src_b = '0; dst_b = '0;
        for (int i = 0; i < 256; i++) maze[i] = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs_a", {busy_a, done_a, fail_a, to_a, mv_a, end_a}, 0);
        check("reset_move_addr_a", {move_a, mem_addr_a, 1'b0, st_a}, 0);
        check("reset_outputs_b", {busy_b, done_b, fail_b, to_b, mv_b, end_b}, 0);
        rst = 1'b0;

        // Open 4x4 grid, corner to corner.
        search_and_check(0, "open4x4", 0, 15, -1, res);
        check("open4x4_done_literal", res, 0);
        check("open4x4_latency_literal", m_lat, 16);
        exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd11, 8'd15};
        play_a("open4x4");

        // Destination walled off.
        maze[11] = 1'b1;
        maze[14] = 1'b1;
        search_and_check(0, "isolated", 0, 15, -1, res);
        check("isolated_fail_literal", res, 1);
        check("isolated_flags", {fail_a, to_a, done_a}, 3'b100);
        maze[11] = 1'b0;
        maze[14] = 1'b0;

        // Source is a wall: FAIL right after INIT.
        maze[3] = 1'b1;
        start_search(0, 3, 0, 1'b0);
        wait_result(0, -1, lat, res);
        check("src_wall_result", res, 1);
        check("src_wall_latency", lat, 1);
        maze[3] = 1'b0;

        // Source equals destination.
        start_search(0, 5, 5, 1'b0);
        wait_result(0, -1, lat, res);
        check("same_cell_result", res, 0);
        check("same_cell_latency", lat, 1);
        exp_q = '{8'd5};
        play_a("same_cell");

        // Start and Run together in DONE: Start wins.
        search_and_check(0, "pre_prio", 0, 1, -1, res);
        model_search(2, 2, 0, 15, 4096);
        start_search(0, 0, 15, 1'b1);
        check("prio_state_init", st_a, 3'd1);
        check("prio_busy_no_move", {busy_a, mv_a}, 2'b10);
        check("prio_init_mem_addr", mem_addr_a, 0);
        wait_result(0, -1, lat, res);
        check("prio_result", res, 0);
        check("prio_latency", lat, m_lat);

        // Start pulsed mid-SCAN with a different target is ignored.
        search_and_check(0, "mid_scan_start", 0, 15, 3, res);
        foreach (m_path[i]) exp_q.push_back(8'(m_path[i]));
        play_a("mid_scan_start");

        // Reset in the middle of playback.
        search_and_check(0, "pre_rst", 0, 15, -1, res);
        @(negedge clk);
        run_a = 1'b1;
        @(negedge clk);
        run_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_play_outputs", {busy_a, done_a, fail_a, to_a, mv_a, end_a}, 0);
        check("rst_play_state", {move_a, 1'b0, st_a}, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_play_quiet", {busy_a, done_a, mv_a, end_a}, 0);
        end

        // Open 16x16 grid with a 10-cycle budget.
        search_and_check(1, "budget16", 0, 255, -1, res);
        check("budget16_timeout_literal", res, 2);
        check("budget16_latency_literal", m_lat, 11);
        check("budget16_flags", {fail_b, to_b}, 2'b11);

        // Randomized 4x4 mazes.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 16; i++) maze[i] = ($urandom_range(0, 99) < 30);
            src = $urandom_range(0, 15);
            dst = $urandom_range(0, 15);
            search_and_check(0, "rand4x4", src, dst, -1, res);
            if (res == 0 && $urandom_range(0, 1) == 1) begin
                foreach (m_path[i]) exp_q.push_back(8'(m_path[i]));
                play_a("rand4x4");
            end
        end

        // Randomized 16x16 mazes under the small budget.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 256; i++) maze[i] = ($urandom_range(0, 99) < 20);
            src = $urandom_range(0, 255);
            dst = (t < 4) ? $urandom_range(0, 255) : ((src + 1) % 256);
            search_and_check(1, "rand16x16", src, dst, -1, res);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
